// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes and output-stage state type for mux_rr_arbiter
package mux_arb_pkg;
   localparam int DATA_W  = 32;
   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;
   typedef enum logic {IDLE, FULL} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority pick, first valid requester after ptr wins
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] in_valid,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   g,
   output logic               any_req
);
   // Scan farthest-first so the nearest valid requester after ptr overwrites
   always_comb begin
      g = ptr;
      for (int i = NUM_REQ; i >= 1; i--)
         if (in_valid[ptr + SEL_W'(i)]) g = ptr + SEL_W'(i);
   end
   assign any_req = |in_valid;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin 4:1 mux arbiter with a registered output stage
// MUX_ARB_BURST_EN adds in_last and locks the grant until the last word of a burst
module mux_rr_arbiter
   import mux_arb_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        in_valid,
   input  logic [NUM_REQ*DATA_W-1:0] in_data,
`ifdef MUX_ARB_BURST_EN
   input  logic [NUM_REQ-1:0]        in_last,
`endif
   output logic [NUM_REQ-1:0]        in_ready,
   output logic [SEL_W-1:0]          sel,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   input  logic                      out_ready
);
   state_t               state;
   logic [SEL_W-1:0]     ptr, last_sel, g;
   logic [NUM_REQ-1:0]   cand;
   logic                 any_req, can_accept, acc;
`ifdef MUX_ARB_BURST_EN
   logic                 lock;
   // A locked burst always belongs to ptr, since every accept moves ptr to the grant
   assign cand = lock ? in_valid & (NUM_REQ'(1) << ptr) : in_valid;
`else
   assign cand = in_valid;
`endif
   rr_pick u_pick (.in_valid(cand), .ptr(ptr), .g(g), .any_req(any_req));
   assign out_valid  = (state == FULL);
   assign can_accept = !out_valid || out_ready;
   assign acc        = can_accept && any_req;
   assign in_ready   = (rst_n && acc) ? NUM_REQ'(1) << g : '0;
   assign sel        = !rst_n ? '0 : any_req ? g : last_sel;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         out_data <= '0;
         ptr      <= SEL_W'(NUM_REQ - 1);
         last_sel <= '0;
`ifdef MUX_ARB_BURST_EN
         lock     <= 1'b0;
`endif
      end else if (acc) begin
         state    <= FULL;
         out_data <= in_data[int'(g) * DATA_W +: DATA_W];
         ptr      <= g;
         last_sel <= g;
`ifdef MUX_ARB_BURST_EN
         lock     <= !in_last[g];
`endif
      end else if (out_ready) begin
         state    <= IDLE;
      end
   end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed stimulus with a queue-based output scoreboard
module tb_mux_rr_arbiter;
   import mux_arb_pkg::*;
   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [NUM_REQ-1:0]        in_valid;
   logic [NUM_REQ*DATA_W-1:0] in_data;
`ifdef MUX_ARB_BURST_EN
   logic [NUM_REQ-1:0]        in_last;
`endif
   logic [NUM_REQ-1:0]        in_ready;
   logic [SEL_W-1:0]          sel;
   logic                      out_valid;
   logic [DATA_W-1:0]         out_data;
   logic                      out_ready;
   int n_cmp = 0;
   int n_err = 0;
   logic [DATA_W-1:0] exp_q[$];

   mux_rr_arbiter dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
`ifdef MUX_ARB_BURST_EN
      .in_last(in_last),
`endif
      .in_ready(in_ready), .sel(sel), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [31:0] d0, d1, d2, d3);
      in_data = {d3, d2, d1, d0};
   endtask

   task automatic grant(input string name, input int r, input logic [31:0] d);
      @(negedge clk);
      chk({name, "_sel"}, 32'(sel), r);
      chk({name, "_ready"}, 32'(in_ready), 32'(1) << r);
      exp_q.push_back(d);
      step();
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got %h expected none", out_data);
         end else begin
            chk("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = '1; out_ready = 1'b0;
      set_data(1, 2, 3, 4);
`ifdef MUX_ARB_BURST_EN
      in_last = '0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_sel", 32'(sel), 0);
      step();
      rst_n = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rr_sel", 32'(sel), k % 4);
         chk("rr_ready", 32'(in_ready), 32'(1) << (k % 4));
         if (k > 0) chk("rr_nobubble", 32'(out_valid), 1);
         exp_q.push_back(32'(k % 4 + 1));
         step();
      end
      grant("bp_acc", 1, 2);
      out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_data", out_data, 2);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_ready", 32'(in_ready), 0);
         step();
      end
      out_ready = 1'b1;
      grant("bp_drain_acc", 2, 3);
      in_valid = '0;
      @(negedge clk);
      chk("idle_sel0", 32'(sel), 2);
      chk("idle_ready", 32'(in_ready), 0);
      step();
      @(negedge clk);
      chk("idle_drained", 32'(out_valid), 0);
      chk("idle_sel1", 32'(sel), 2);
      step();
      in_valid = '1;
      grant("idle_ptr", 3, 4);
      in_valid = 4'b0001;
      set_data(32'hDEADBEEF, 2, 3, 4);
      grant("wrap0", 0, 32'hDEADBEEF);
      in_valid = 4'b1000;
      @(negedge clk);
      chk("wrap_data", out_data, 32'hDEADBEEF);
      chk("wrap3_sel", 32'(sel), 3);
      chk("wrap3_ready", 32'(in_ready), 32'b1000);
      exp_q.push_back(4);
      step();
      in_valid = '0;
      step();
      out_ready = 1'b0; in_valid = 4'b0010;
      set_data(1, 2, 3, 4);
      step();
      in_valid = '1;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_valid), 0);
      chk("midrst_data", out_data, 0);
      chk("midrst_ready", 32'(in_ready), 0);
      chk("midrst_sel", 32'(sel), 0);
      step();
      rst_n = 1'b1; out_ready = 1'b1;
      grant("post_rst", 0, 1);
`ifdef MUX_ARB_BURST_EN
      in_valid = 4'b0111;
      set_data(1, 32'h11, 3, 4);
      grant("burst0", 1, 32'h11);
      set_data(1, 32'h12, 3, 4);
      grant("burst1", 1, 32'h12);
      set_data(1, 32'h13, 3, 4);
      in_last = 4'b0010;
      grant("burst2", 1, 32'h13);
      in_last = '0; in_valid = 4'b0101;
      grant("burst_next", 2, 3);
      grant("burst_then", 0, 1);
`endif
      in_valid = '0; out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      chk("drain_left", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
